dmem_port_arbiter: RTL

//  Shares the single-port data memory (data_mem_inst) between the CPU load/store unit and a
//  DMA/debug-loader port. Grants one access per cycle: CPU has priority, and a starvation

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_starve_ctr.sv | 35 +++
 rtl/dmem_port_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared definitions for the data-memory port arbiter. It holds the data and
//   byte-enable widths, the read-owner encoding that tags each in-flight load,
//   and the packed payload that the grant mux routes to memory.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Identifies which requester owns the read data returning next cycle.
    typedef logic [1:0] own_t;
    localparam own_t OWN_NONE = 2'd0;
    localparam own_t OWN_CPU  = 2'd1;
    localparam own_t OWN_DMA  = 2'd2;

    // Address-independent part of an access. The address width is a module
    // parameter, so the address is routed separately.
    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_pl_t;

endpackage

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr
//   Saturating up-counter with a synchronous clear and a threshold flag.
//   - clr has priority over inc.
//   - The count stops at MAX.
//   - at_max is high while cnt == MAX.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : clear the count to 0 this cycle
//   inc        : increment the count (ignored once saturated)
//   cnt        : current count
//   at_max     : cnt has reached MAX
module dmem_starve_ctr #(
    parameter int MAX   = 8,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);

    assign at_max = (cnt == CNT_W'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Lets the CPU load/store unit and the DMA/debug loader share the
//   single-port data memory. The arbiter grants one access per cycle.
//   - The CPU has priority.
//   - A starvation counter forces a DMA win after STARVE_MAX denied cycles.
//   - dma_lock lets the DMA keep the port for up to LOCK_MAX back-to-back grants.
//   Load data comes back one cycle after the grant. It is steered to the
//   requester that issued the load.
// Ports
//   clk, rst_n                              : clock, async active-low reset
//   cpu_req/we/addr/wdata/be                : CPU request bundle
//   cpu_gnt                                 : CPU access accepted (combinational)
//   cpu_rvalid/cpu_rdata                    : CPU load return
//   dma_req/we/addr/wdata/be, dma_lock      : DMA request bundle, burst hold
//   dma_gnt, dma_rvalid/dma_rdata           : DMA grant and load return
//   mem_en/we/addr/wdata/be                 : memory command (all 0 when idle)
//   mem_rdata                               : memory read data (1-cycle latency)
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 8,
    parameter int LOCK_MAX   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // CPU port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [BE_W-1:0]   cpu_be,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    // DMA port
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic [BE_W-1:0]   dma_be,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    // Memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STARVE_CW = $clog2(STARVE_MAX + 1);
    localparam int LOCK_CW   = $clog2(LOCK_MAX + 1);

    logic [STARVE_CW-1:0] starve_cnt;
    logic [LOCK_CW-1:0]   lock_cnt;
    logic                 starve_max;
    logic                 lock_max;
    logic                 last_dma;
    logic                 force_dma;
    own_t                 rd_owner;
    mem_pl_t              cpu_pl, dma_pl, mem_pl;

    // ---------------------------------------------------------------
    // Grant
    // ---------------------------------------------------------------
    // DMA is forced when it has starved long enough, or when it holds the
    // lock and its burst is still under the cap. The cap means the lock can
    // never keep the CPU out for more than LOCK_MAX consecutive grants.
    assign force_dma = dma_req & (starve_max | (dma_lock & last_dma & ~lock_max));
    assign cpu_gnt   = cpu_req & ~force_dma;
    assign dma_gnt   = dma_req & ~cpu_gnt;

    // ---------------------------------------------------------------
    // Fairness counters
    // ---------------------------------------------------------------
    dmem_starve_ctr #(.MAX(STARVE_MAX), .CNT_W(STARVE_CW)) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (dma_gnt | ~dma_req),
        .inc    (dma_req & ~dma_gnt),
        .cnt    (starve_cnt),
        .at_max (starve_max)
    );

    // The lock counter counts only DMA grants made while the lock is held.
    // A CPU grant, lock release or idle cycle clears it.
    dmem_starve_ctr #(.MAX(LOCK_MAX), .CNT_W(LOCK_CW)) u_lock (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (~(dma_gnt & dma_lock)),
        .inc    (dma_gnt & dma_lock),
        .cnt    (lock_cnt),
        .at_max (lock_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_dma <= 1'b0;
        else
            last_dma <= dma_gnt;
    end

    // ---------------------------------------------------------------
    // Memory command mux: zeros when nothing is granted
    // ---------------------------------------------------------------
    assign cpu_pl = '{we: cpu_we, wdata: cpu_wdata, be: cpu_be};
    assign dma_pl = '{we: dma_we, wdata: dma_wdata, be: dma_be};

    always_comb begin
        mem_pl   = '0;
        mem_addr = '0;
        if (cpu_gnt) begin
            mem_pl   = cpu_pl;
            mem_addr = cpu_addr;
        end else if (dma_gnt) begin
            mem_pl   = dma_pl;
            mem_addr = dma_addr;
        end
    end

    assign mem_en    = cpu_gnt | dma_gnt;
    assign mem_we    = mem_pl.we;
    assign mem_wdata = mem_pl.wdata;
    assign mem_be    = mem_pl.be;

    // ---------------------------------------------------------------
    // Read return
    // ---------------------------------------------------------------
    // Each granted load tags the next cycle's mem_rdata with its owner.
    // A new grant can issue while the previous data returns, so the path is
    // fully pipelined. Reset drops any load that is still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_owner <= OWN_NONE;
        else if (cpu_gnt && !cpu_we)
            rd_owner <= OWN_CPU;
        else if (dma_gnt && !dma_we)
            rd_owner <= OWN_DMA;
        else
            rd_owner <= OWN_NONE;
    end

    assign cpu_rvalid = (rd_owner == OWN_CPU);
    assign dma_rvalid = (rd_owner == OWN_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

    // ---------------------------------------------------------------
    // Protocol / invariant assertions (simulation only)
    // ---------------------------------------------------------------
    a_one_gnt : assert property (@(posedge clk) disable iff (!rst_n)
        !(cpu_gnt && dma_gnt));

    // A waiting requester may withdraw. While it still requests, its payload
    // must not change.
    a_cpu_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (cpu_req && !cpu_gnt) |=>
            (!cpu_req || $stable({cpu_we, cpu_addr, cpu_wdata, cpu_be})));

    a_dma_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (dma_req && !dma_gnt) |=>
            (!dma_req || $stable({dma_we, dma_addr, dma_wdata, dma_be})));

    a_starve_rng : assert property (@(posedge clk) disable iff (!rst_n)
        starve_cnt <= STARVE_CW'(STARVE_MAX));

    a_lock_rng : assert property (@(posedge clk) disable iff (!rst_n)
        lock_cnt <= LOCK_CW'(LOCK_MAX));

endmodule
